// File: rtl/comparator_tester_pkg.sv
// Shared types and sizes for the exhaustive 2-bit comparator tester.
// The state enum is also exported on the debug port so checkers can bind to it.
package comparator_tester_pkg;

    localparam int NUM_VECTORS = 16;
    localparam int IDX_W       = 4;
    localparam int ERR_W       = 5;
    localparam int CNT_W       = 4;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_DRIVE  = 3'd1,
        ST_SETTLE = 3'd2,
        ST_CHECK  = 3'd3,
        ST_DONE   = 3'd4
    } state_e;

endpackage

// File: rtl/comparator_tester_ref.sv
// Golden model of a 2-bit magnitude comparator; supplies the expected
// response for the vector currently held on b/a.
module comparator_ref (
    input  logic [1:0] b_i,
    input  logic [1:0] a_i,
    output logic       exp_b_gt_o,
    output logic       exp_b_a_eq_o,
    output logic       exp_a_gt_o
);

    assign exp_b_gt_o   = (b_i > a_i);
    assign exp_b_a_eq_o = (b_i == a_i);
    assign exp_a_gt_o   = (a_i > b_i);

endmodule

// File: rtl/comparator_tester.sv
// Drives all 16 {b,a} vectors into an external 2-bit comparator, waits a
// settle time per vector, and tallies mismatching responses.
module comparator_tester
    import comparator_tester_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic [1:0]       b,
    output logic [1:0]       a,
    input  logic             b_gt,
    input  logic             b_a_eq,
    input  logic             a_gt,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_cnt,
    output logic [IDX_W-1:0] first_fail,
    output state_e           dbg_state
);

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [ERR_W-1:0]   err_q, err_d;
    logic [IDX_W-1:0]   ff_q, ff_d;
    logic [1:0]         b_q, b_d, a_q, a_d;
    logic               exp_b_gt, exp_b_a_eq, exp_a_gt;
    logic               mismatch;
    logic               last_vec;

    comparator_ref u_ref (
        .b_i          (b_q),
        .a_i          (a_q),
        .exp_b_gt_o   (exp_b_gt),
        .exp_b_a_eq_o (exp_b_a_eq),
        .exp_a_gt_o   (exp_a_gt)
    );

    assign mismatch = ({b_gt, b_a_eq, a_gt} != {exp_b_gt, exp_b_a_eq, exp_a_gt});
    assign last_vec = (idx_q == IDX_W'(NUM_VECTORS - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            err_q   <= '0;
            ff_q    <= '0;
            b_q     <= '0;
            a_q     <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            ff_q    <= ff_d;
            b_q     <= b_d;
            a_q     <= a_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (start) state_d = ST_DRIVE;
            ST_DRIVE:  state_d = ST_SETTLE;
            ST_SETTLE: if (cnt_q == CNT_W'(1)) state_d = ST_CHECK;
            ST_CHECK:  state_d = last_vec ? ST_DONE : ST_DRIVE;
            ST_DONE:   if (start) state_d = ST_DRIVE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // The settle counter is loaded on leaving DRIVE and counts S..1 in SETTLE.
    always_comb begin
        idx_d = idx_q;
        cnt_d = cnt_q;
        err_d = err_q;
        ff_d  = ff_q;
        b_d   = b_q;
        a_d   = a_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    idx_d = '0;
                    err_d = '0;
                    ff_d  = '0;
                end
            end
            ST_DRIVE: begin
                b_d   = idx_q[3:2];
                a_d   = idx_q[1:0];
                cnt_d = CNT_W'(SETTLE_CYCLES);
            end
            ST_SETTLE: cnt_d = cnt_q - CNT_W'(1);
            ST_CHECK: begin
                if (mismatch) begin
                    err_d = err_q + ERR_W'(1);
                    if (err_q == '0) ff_d = idx_q;
                end
                if (!last_vec) idx_d = idx_q + IDX_W'(1);
            end
            default: ;
        endcase
    end

    always_comb begin
        busy       = (state_q == ST_DRIVE) || (state_q == ST_SETTLE) || (state_q == ST_CHECK);
        done       = (state_q == ST_DONE);
        pass       = done && (err_q == '0);
        err_cnt    = err_q;
        first_fail = ff_q;
        b          = b_q;
        a          = a_q;
        dbg_state  = state_q;
    end

endmodule

// File: tb/tb_comparator_tester.sv
// Directed bench: three tester instances (settle 2, 1, 15) facing a behavioural
// comparator that can be switched into faulty modes.
module tb_comparator_tester;
    import comparator_tester_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start_r [3];
    logic [1:0] b_w [3];
    logic [1:0] a_w [3];
    logic       b_gt_w [3];
    logic       eq_w [3];
    logic       a_gt_w [3];
    logic       busy_w [3];
    logic       done_w [3];
    logic       pass_w [3];
    logic [4:0] err_w [3];
    logic [3:0] ff_w [3];
    state_e     st_w [3];

    int mode;   // 0 correct, 1 eq stuck at 0, 2 gt outputs swapped
    int tests;
    int fails;

    always #5 clk = ~clk;

    function automatic logic [2:0] model(input int m, input logic [1:0] bb, input logic [1:0] aa);
        logic gt, eq, lt;
        gt = (bb > aa);
        eq = (bb == aa);
        lt = (aa > bb);
        if (m == 1) eq = 1'b0;
        if (m == 2) return {lt, eq, gt};
        return {gt, eq, lt};
    endfunction

    for (genvar g = 0; g < 3; g++) begin : g_resp
        assign {b_gt_w[g], eq_w[g], a_gt_w[g]} = model(mode, b_w[g], a_w[g]);
    end

    comparator_tester #(.SETTLE_CYCLES(2)) u_s2 (
        .clk(clk), .rst_n(rst_n), .start(start_r[0]), .b(b_w[0]), .a(a_w[0]),
        .b_gt(b_gt_w[0]), .b_a_eq(eq_w[0]), .a_gt(a_gt_w[0]), .busy(busy_w[0]),
        .done(done_w[0]), .pass(pass_w[0]), .err_cnt(err_w[0]), .first_fail(ff_w[0]),
        .dbg_state(st_w[0])
    );

    comparator_tester #(.SETTLE_CYCLES(1)) u_s1 (
        .clk(clk), .rst_n(rst_n), .start(start_r[1]), .b(b_w[1]), .a(a_w[1]),
        .b_gt(b_gt_w[1]), .b_a_eq(eq_w[1]), .a_gt(a_gt_w[1]), .busy(busy_w[1]),
        .done(done_w[1]), .pass(pass_w[1]), .err_cnt(err_w[1]), .first_fail(ff_w[1]),
        .dbg_state(st_w[1])
    );

    comparator_tester #(.SETTLE_CYCLES(15)) u_s15 (
        .clk(clk), .rst_n(rst_n), .start(start_r[2]), .b(b_w[2]), .a(a_w[2]),
        .b_gt(b_gt_w[2]), .b_a_eq(eq_w[2]), .a_gt(a_gt_w[2]), .busy(busy_w[2]),
        .done(done_w[2]), .pass(pass_w[2]), .err_cnt(err_w[2]), .first_fail(ff_w[2]),
        .dbg_state(st_w[2])
    );

    task automatic check_all_zero(input string name);
        for (int i = 0; i < 3; i++) begin
            tests++;
            if ({b_w[i], a_w[i], busy_w[i], done_w[i], pass_w[i], err_w[i], ff_w[i]} !== 15'd0 ||
                st_w[i] !== ST_IDLE) begin
                fails++;
                $display("FAIL %s inst%0d: b=%0d a=%0d busy=%b done=%b pass=%b err=%0d ff=%0d st=%0d, expected all 0 in IDLE",
                         name, i, b_w[i], a_w[i], busy_w[i], done_w[i], pass_w[i], err_w[i], ff_w[i], st_w[i]);
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) start_r[i] = 1'b0;
        #1;
        check_all_zero("reset");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Starts a run on instance i (per-vector period p) and checks duration,
    // the b/a sequence cycle by cycle, and the final result.
    task automatic run(input int i, input int p, input int exp_err, input int exp_ff,
                       input logic exp_pass, input bit hold, input string name);
        int  t;
        bit  got;
        bit  seq_bad;
        int  bad_t;
        got = 1'b0;
        seq_bad = 1'b0;
        bad_t = 0;
        @(negedge clk);
        start_r[i] = 1'b1;
        @(posedge clk);
        #1;
        tests++;
        if (busy_w[i] !== 1'b1) begin
            fails++;
            $display("FAIL %s busy_after_start: busy=%b, expected 1", name, busy_w[i]);
        end
        @(negedge clk);
        if (!hold) start_r[i] = 1'b0;
        for (t = 1; t <= 16 * p + 8; t++) begin
            @(posedge clk);
            #1;
            if ({b_w[i], a_w[i]} !== 4'((t - 1) / p) && !seq_bad) begin
                seq_bad = 1'b1;
                bad_t = t;
            end
            if (done_w[i] === 1'b1) begin
                got = 1'b1;
                break;
            end
        end
        tests++;
        if (!got || t != 16 * p) begin
            fails++;
            $display("FAIL %s run_length: done after %0d cycles (seen=%b), expected %0d", name, t, got, 16 * p);
        end
        tests++;
        if (seq_bad) begin
            fails++;
            $display("FAIL %s vector_sequence: wrong b/a at cycle %0d, expected index %0d", name, bad_t, (bad_t - 1) / p);
        end
        tests++;
        if (err_w[i] !== 5'(exp_err) || pass_w[i] !== exp_pass || busy_w[i] !== 1'b0) begin
            fails++;
            $display("FAIL %s result: err=%0d pass=%b busy=%b, expected err=%0d pass=%b busy=0",
                     name, err_w[i], pass_w[i], busy_w[i], exp_err, exp_pass);
        end
        if (exp_err != 0) begin
            tests++;
            if (ff_w[i] !== 4'(exp_ff)) begin
                fails++;
                $display("FAIL %s first_fail: got %0d, expected %0d", name, ff_w[i], exp_ff);
            end
        end
    endtask

    task automatic test_reset_mid();
        int n;
        mode = 0;
        @(negedge clk);
        start_r[0] = 1'b1;
        @(negedge clk);
        start_r[0] = 1'b0;
        n = 0;
        while ({b_w[0], a_w[0]} !== 4'd5 && n < 200) begin
            @(negedge clk);
            n++;
        end
        tests++;
        if (n >= 200) begin
            fails++;
            $display("FAIL reset_mid reach_idx5: vector 5 never driven, expected within 200 cycles");
        end
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("reset_mid");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        run(0, 4, 0, 0, 1'b1, 1'b0, "after_reset");
    endtask

    task automatic test_start_held();
        int n;
        mode = 2;
        run(0, 4, 12, 1, 1'b0, 1'b1, "held_start");
        mode = 0;
        @(posedge clk);
        #1;
        tests++;
        if (busy_w[0] !== 1'b1 || done_w[0] !== 1'b0 || err_w[0] !== 5'd0) begin
            fails++;
            $display("FAIL held_restart: busy=%b done=%b err=%0d, expected busy=1 done=0 err=0",
                     busy_w[0], done_w[0], err_w[0]);
        end
        @(negedge clk);
        start_r[0] = 1'b0;
        n = 0;
        while (done_w[0] !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        tests++;
        if (n >= 200 || pass_w[0] !== 1'b1 || err_w[0] !== 5'd0) begin
            fails++;
            $display("FAIL held_second_run: waited %0d pass=%b err=%0d, expected done with pass=1 err=0",
                     n, pass_w[0], err_w[0]);
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        mode = 0;
        test_reset();
        mode = 0;
        run(0, 4, 0, 0, 1'b1, 1'b0, "correct_s2");
        mode = 1;
        run(0, 4, 4, 0, 1'b0, 1'b0, "eq_stuck0");
        mode = 2;
        run(0, 4, 12, 1, 1'b0, 1'b0, "gt_swapped");
        test_reset_mid();
        test_start_held();
        mode = 0;
        run(1, 3, 0, 0, 1'b1, 1'b0, "settle1");
        run(2, 17, 0, 0, 1'b1, 1'b0, "settle15");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/comparator_tester.md
COMPARATOR_TESTER -- requirements
Module: comparator_tester

Interface
REQ-001 Parameter SETTLE_CYCLES, default 2, sets the cycles between driving a vector and sampling responses; legal range 1..15.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst_n  input  1  reset; asynchronous, active-low.
REQ-004 start  input  1  request a full test run; sampled on rising clk.
REQ-005 b  output  2  operand b driven to the 2-bit comparator under test; registered.
REQ-006 a  output  2  operand a driven to the comparator under test; registered.
REQ-007 b_gt  input  1  comparator response, b greater than a.
REQ-008 b_a_eq  input  1  comparator response, b equal to a.
REQ-009 a_gt  input  1  comparator response, a greater than b.
REQ-010 busy  output  1  high while a run is in progress.
REQ-011 done  output  1  high while holding the result of a completed run.
REQ-012 pass  output  1  high with done when no mismatches occurred.
REQ-013 err_cnt  output  5  mismatching vectors in the current or last run, 0..16.
REQ-014 first_fail  output  4  index {b,a} of the first mismatching vector; valid only when err_cnt nonzero.

Function
REQ-015 The FSM SHALL use the states IDLE, DRIVE, SETTLE, CHECK and DONE.
REQ-016 IDLE -> DRIVE when start=1; vector index idx (4 bits) cleared, err_cnt and first_fail cleared.
REQ-017 The vector order SHALL be exhaustive: idx 0..15, with b=idx[3:2] (outer) and a=idx[1:0] (inner).
REQ-018 DRIVE SHALL last 1 cycle, load b/a from idx, then go to SETTLE.
REQ-019 SETTLE SHALL last exactly SETTLE_CYCLES cycles, counted by a down-counter, then go to CHECK.
REQ-020 CHECK SHALL last 1 cycle and compare the inputs against expected (b>a, b==a, a>b) on the held b/a.
REQ-021 On mismatch in any bit, err_cnt SHALL increment by 1, and first_fail SHALL capture idx only if err_cnt was 0.
REQ-022 CHECK -> DRIVE with idx+1 if idx<15, otherwise -> DONE; idx SHALL not wrap within a run.
REQ-023 Per-vector cost SHALL be 2+SETTLE_CYCLES cycles; a run SHALL be 16*(2+SETTLE_CYCLES) cycles from the start edge to done high.
REQ-024 busy=1 in DRIVE, SETTLE and CHECK; done=1 only in DONE; pass=done AND (err_cnt==0).
REQ-025 start SHALL be ignored while busy.
REQ-026 DONE SHALL hold results until start=1, which SHALL restart exactly as from IDLE (REQ-016).
REQ-027 b and a SHALL hold their last values in DONE, and read 0 in IDLE after reset.

Reset
REQ-028 rst_n low SHALL immediately force IDLE, with b=0, a=0, busy=0, done=0, pass=0, err_cnt=0, first_fail=0, idx=0 and settle counter=0.
REQ-029 Assertion of rst_n mid-run SHALL abort the run with no partial result retained; the first start after release begins at idx 0.

Structure
REQ-030 Package comparator_tester_pkg SHALL hold the state encoding, NUM_VECTORS=16 and the widths of idx and err_cnt.
REQ-031 Sub-module comparator_ref (combinational golden model: 2-bit b, a -> exp_b_gt, exp_b_a_eq, exp_a_gt) SHALL produce the expected values; the FSM and counters stay in comparator_tester.

Verification
REQ-032 Correct comparator attached, SETTLE_CYCLES=2, single start pulse -> done rises 64 cycles after the start edge, pass=1, err_cnt=0.
REQ-033 Faulty model with b_a_eq stuck at 0 -> err_cnt=4, first_fail=0, pass=0.
REQ-034 Faulty model with b_gt and a_gt swapped -> err_cnt=12, first_fail=1, pass=0.
REQ-035 rst_n low during vector idx=5 -> all outputs 0 in the same cycle; new start -> full 64-cycle run from idx 0.
REQ-036 start held high throughout a run -> no restart while busy; new run begins on the cycle after DONE is entered, with err_cnt cleared.
REQ-037 SETTLE_CYCLES=1 and 15 -> runs of 48 and 272 cycles, with b/a stable across every CHECK.
